// File: rtl/image_sender.sv
// image_sender: buffers one 25-word image and streams it to the SNN loader
// as two NEXT-strobed chunks, then samples the neuron outputs after a run.
module image_sender #(
  parameter int WORDS      = 25,
  parameter int CHUNK      = 14,
  parameter int HOLD       = 2,
  parameter int GAP        = 4,
  parameter int RUN_CYCLES = 30000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  input  logic                  start,
  input  logic [1:0]            neurons_in,
  output logic [CHUNK*32-1:0]   data_out,
  output logic                  next,
  output logic                  finish,
  output logic                  full,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            result
);

  localparam int HG   = (HOLD > GAP) ? HOLD : GAP;
  localparam int CMAX = (HG > RUN_CYCLES) ? HG : RUN_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int PW   = $clog2(WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD0,
    S_GAP0,
    S_HOLD1,
    S_GAP1
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       wptr_q, wptr_d;
  logic [31:0]         mem_q [WORDS];
  logic [CHUNK*32-1:0] data_q, data_d;
  logic [CHUNK*32-1:0] chunk0, chunk1;
  logic                next_q, next_d;
  logic                finish_q, finish_d;
  logic                done_q, done_d;
  logic [1:0]          result_q, result_d;
  logic                we;

  assign full     = (wptr_q == PW'(WORDS));
  assign busy     = (state_q != S_IDLE);
  assign we       = wr_en && !busy && !full;
  assign data_out = data_q;
  assign next     = next_q;
  assign finish   = finish_q;
  assign done     = done_q;
  assign result   = result_q;

  // Words past the end of the image leave their chunk-1 slots at zero.
  always_comb begin
    chunk0 = '0;
    chunk1 = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (w < CHUNK) chunk0[32*w +: 32] = mem_q[w];
      else           chunk1[32*(w-CHUNK) +: 32] = mem_q[w];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wptr_d   = wptr_q;
    data_d   = data_q;
    next_d   = next_q;
    finish_d = finish_q;
    done_d   = 1'b0;
    result_d = result_q;
    if (we) wptr_d = wptr_q + PW'(1);
    unique case (state_q)
      S_IDLE: begin
        if (start && full) begin
          state_d = S_HOLD0;
          cnt_d   = CW'(HOLD - 1);
          data_d  = chunk0;
          next_d  = 1'b1;
        end
      end
      S_HOLD0: begin
        if (cnt_q == '0) begin
          state_d = S_GAP0;
          cnt_d   = CW'(GAP - 1);
          next_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP0: begin
        if (cnt_q == '0) begin
          state_d  = S_HOLD1;
          cnt_d    = CW'(RUN_CYCLES - 1);
          data_d   = chunk1;
          next_d   = 1'b1;
          finish_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD1: begin
        if (cnt_q == '0) begin
          state_d  = S_GAP1;
          cnt_d    = CW'(GAP - 1);
          next_d   = 1'b0;
          finish_d = 1'b0;
          done_d   = 1'b1;
          result_d = neurons_in;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP1: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          wptr_d  = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wptr_q   <= '0;
      data_q   <= '0;
      next_q   <= 1'b0;
      finish_q <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wptr_q   <= wptr_d;
      data_q   <= data_d;
      next_q   <= next_d;
      finish_q <= finish_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_image_sender.sv
// tb_image_sender: randomized image loads checked against a
// cycle-offset timeline model of the chunked transfer.
module tb_image_sender;

  localparam int WORDS = 25;
  localparam int CHUNK = 14;
  localparam int HOLD  = 2;
  localparam int GAP   = 4;
  localparam int RUN   = 10;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                wr_en;
  logic [31:0]         wr_data;
  logic                start;
  logic [1:0]          neurons_in;
  logic [CHUNK*32-1:0] data_out;
  logic                next, finish, full, busy, done;
  logic [1:0]          result;

  int errs = 0;
  int checks = 0;

  logic [31:0] img [WORDS];
  int nimg = 0;

  image_sender #(
    .WORDS(WORDS), .CHUNK(CHUNK), .HOLD(HOLD),
    .GAP(GAP), .RUN_CYCLES(RUN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en),
    .wr_data(wr_data), .start(start),
    .neurons_in(neurons_in), .data_out(data_out),
    .next(next), .finish(finish), .full(full),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [CHUNK*32-1:0] got,
                     input logic [CHUNK*32-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CHUNK*32-1:0] exp_chunk(input int c);
    logic [CHUNK*32-1:0] r;
    r = '0;
    for (int k = 0; k < CHUNK; k++) begin
      if (c*CHUNK + k < WORDS) r[32*k +: 32] = img[c*CHUNK + k];
    end
    return r;
  endfunction

  task automatic wr(input logic [31:0] v);
    wr_en = 1'b1;
    wr_data = v;
    tick();
    wr_en = 1'b0;
    if (nimg < WORDS) begin
      img[nimg] = v;
      nimg++;
    end
    chk("full", full, nimg == WORDS);
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) wr($urandom);
  endtask

  // d counts edges since the accepted start edge.
  task automatic run_xfer(input logic [1:0] neur, input bit disturb);
    int dn;
    int ndone;
    logic [CHUNK*32-1:0] e0, e1;
    dn = HOLD + GAP + RUN + 1;
    e0 = exp_chunk(0);
    e1 = exp_chunk(1);
    ndone = 0;
    neurons_in = neur;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int d = 1; d <= dn + GAP; d++) begin
      bit en_f, en_n;
      en_f = (d >= HOLD + GAP + 1) && (d <= HOLD + GAP + RUN);
      en_n = (d <= HOLD) || en_f;
      chk("next", next, en_n);
      chk("finish", finish, en_f);
      chk("busy", busy, d < dn + GAP);
      chk("done", done, d == dn);
      chk("data", data_out, (d <= HOLD + GAP) ? e0 : e1);
      if (done) begin
        ndone++;
        chk("result", result, neur);
      end
      if (disturb && d == HOLD + 2) begin
        wr_en = 1'b1;
        wr_data = $urandom;
      end
      if (disturb && d == HOLD + GAP + 3) start = 1'b1;
      tick();
      wr_en = 1'b0;
      start = 1'b0;
    end
    neurons_in = ~neur;
    chk("done_count", ndone, 1);
    chk("full_after", full, 1'b0);
    chk("result_hold", result, neur);
    chk("data_hold", data_out, e1);
    nimg = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    wr_data = '0;
    start = 1'b0;
    neurons_in = 2'b00;
    #3;
    chk("rst_next", next, 1'b0);
    chk("rst_finish", finish, 1'b0);
    chk("rst_full", full, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 2'b00);
    chk("rst_data", data_out, '0);
    #19;
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < WORDS; i++) wr(32'(i));
    wr(32'hDEAD_BEEF);
    chk("full_26th", full, 1'b1);
    run_xfer(2'b10, 1'b0);

    // 24 words only: start must be ignored
    load_random(WORDS - 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("short_busy", busy, 1'b0);
      chk("short_next", next, 1'b0);
      tick();
    end
    // 25th write and start together: write lands, start rejected
    wr_en = 1'b1;
    wr_data = $urandom;
    start = 1'b1;
    tick();
    wr_en = 1'b0;
    start = 1'b0;
    img[nimg] = wr_data;
    nimg++;
    chk("same_full", full, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("same_busy", busy, 1'b0);
      chk("same_next", next, 1'b0);
      tick();
    end
    run_xfer(2'b01, 1'b0);

    load_random(WORDS);
    run_xfer(2'($urandom_range(0, 3)), 1'b1);

    // reset in the middle of the run window
    load_random(WORDS);
    neurons_in = 2'b11;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < HOLD + GAP + 3; i++) tick();
    chk("pre_rst_finish", finish, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_next", next, 1'b0);
    chk("arst_finish", finish, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_full", full, 1'b0);
    chk("arst_data", data_out, '0);
    nimg = 0;
    #3;
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_next", next, 1'b0);
      tick();
    end
    load_random(WORDS);
    run_xfer(2'($urandom_range(0, 3)), 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/image_sender.md
# image_sender

Transmitter end of the SNN image-load link. Buffers one 800-bit image (25 × 32-bit words) written by the host, then drives the chunked NEXT/FINISH/DATA protocol consumed by the SNN perceptron loader: chunk 0 carries words 0–13, and chunk 1 (FINISH high) carries words 14–24. It holds FINISH for a fixed run window, samples the network's neuron outputs, and reports the result.

## Interface
- WORDS, 25, image words per transfer (fixed by the 800-bit image)
- CHUNK, 14, words per bus chunk (bus is CHUNK×32 bits)
- HOLD, 2, cycles NEXT stays high per chunk (≥1)
- GAP, 4, cycles NEXT stays low between chunks and after the run (≥1)
- RUN_CYCLES, 30000, cycles FINISH/NEXT stay high after chunk 1 before the result is sampled (≥1)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  host word write strobe
- wr_data  in  32  host word
- start  in  1  single-cycle send request
- neurons_in  in  2  SNN neuron outputs
- data_out  out  CHUNK*32  chunk bus; word k occupies bits [32k+31:32k]
- next  out  1  chunk-valid strobe to the loader
- finish  out  1  last-chunk / run flag to the loader
- full  out  1  all WORDS words buffered
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when result is valid
- result  out  2  neurons_in sampled at end of run

## Operation
- Buffer: 25×32 register array, write pointer wptr (0..WORDS). wr_en with !busy and !full stores wr_data at wptr, and wptr increments. full = (wptr == WORDS).
- Writes while busy or full are ignored, with no pointer change.
- start is accepted only in IDLE with full=1. Otherwise it is ignored with no state change.
- States:
  - IDLE: accepted start → HOLD0. data_out loads words 0..13 and next=1.
  - HOLD0: next=1, finish=0 for HOLD cycles → GAP0, next=0.
  - GAP0: next=0 for GAP cycles → HOLD1. data_out loads words 14..24 into slots 0..10, slots 11..13 are zero, and next=1, finish=1 set together.
  - HOLD1: next=1, finish=1 for RUN_CYCLES cycles, then result ← neurons_in and done=1 for one cycle. next and finish drop to 0 in the same cycle → GAP1.
  - GAP1: next=0, finish=0 for GAP cycles. wptr clears to 0 on exit → IDLE.
- busy = (state != IDLE).
- data_out is registered and changes only on entry to HOLD0 or HOLD1. It is stable throughout each hold and gap, and is held after completion.
- finish never rises before chunk 0 has completed its HOLD and GAP.
- A single counter (width ≥ clog2 of max(HOLD,GAP,RUN_CYCLES)+1) is reused per state and reloads on every state entry.
- result is held until the next done pulse.

## Timing
- Reset (async, rst_n=0), same cycle:
  - state=IDLE, wptr=0, data_out=0, next=0, finish=0, full=0, busy=0, done=0, result=0.
- start sampled at edge t (accepted): at t+1, next=1, busy=1, data_out=chunk 0.
- next falls at t+1+HOLD and rises again at t+1+HOLD+GAP with finish=1.
- done pulses at t+1+HOLD+GAP+RUN_CYCLES, with next=finish=0 from that edge.
- busy falls GAP cycles after done.
- wr_en and start in the same cycle while IDLE with wptr=24: the write completes; start is rejected because full is still 0.
- start during busy is ignored; the transfer is not restarted.
- rst_n low mid-transfer: next and finish drop immediately and the buffer is invalidated (wptr=0).

## Test plan
- Reset, then write words 0x0000_0000..0x0000_0018 (value = index): full rises after the 25th write. A 26th write with value 0xDEAD_BEEF leaves wptr=25 and the buffer unchanged.
- start with HOLD=2, GAP=4, RUN_CYCLES=10:
  - next is high for 2 cycles with data_out words 0..13 = 0..13.
  - next is low for 4 cycles.
  - next and finish are high for 10 cycles with slots 0..10 = 14..24 and slots 11..13 = 0.
  - done pulses once.
- neurons_in=2'b10 held during the run: result=2'b10 at done. A second image with neurons_in=2'b01 gives result=2'b01.
- start with only 24 words buffered: no response, busy stays 0, next stays 0. The 25th write followed by start then proceeds normally.
- start re-pulsed during HOLD1 and wr_en during GAP0: no restart, buffer unchanged, done timing identical to the undisturbed run.
- rst_n asserted during HOLD1:
  - next, finish and busy go to 0 asynchronously; wptr=0.
  - After release, start is ignored until 25 new words are written.
